// File: rtl/hazard_unit_param_pkg.sv
// rtl/hazard_unit_param_pkg.sv - opcodes, FSM state encoding and instruction field helpers for the hazard unit
package hazard_unit_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALTED     = 2'd3
    } hz_state_e;

    localparam logic [3:0] OPC_LW  = 4'b1000;
    localparam logic [3:0] OPC_SW  = 4'b1001;
    localparam logic [3:0] OPC_LHB = 4'b1010;
    localparam logic [3:0] OPC_LLB = 4'b1011;
    localparam logic [3:0] OPC_B   = 4'b1100;
    localparam logic [3:0] OPC_JAL = 4'b1101;
    localparam logic [3:0] OPC_JR  = 4'b1110;
    localparam logic [3:0] OPC_HLT = 4'b1111;

    // Instructions are zero-extended to 64 bits so one helper serves every INSTR_W.
    function automatic logic [63:0] field_bits(input logic [63:0] instr, input int lsb, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (instr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] opc_field(input logic [63:0] instr, input int instr_w, input int opc_w);
        return field_bits(instr, instr_w - opc_w, opc_w);
    endfunction

    function automatic logic [63:0] fld_a(input logic [63:0] instr, input int instr_w, input int opc_w,
                                          input int reg_w);
        return field_bits(instr, instr_w - opc_w - reg_w, reg_w);
    endfunction

    function automatic logic [63:0] fld_b(input logic [63:0] instr, input int instr_w, input int opc_w,
                                          input int reg_w);
        return field_bits(instr, instr_w - opc_w - 2 * reg_w, reg_w);
    endfunction

    function automatic logic [63:0] fld_c(input logic [63:0] instr, input int instr_w, input int opc_w,
                                          input int reg_w);
        return field_bits(instr, instr_w - opc_w - 3 * reg_w, reg_w);
    endfunction

endpackage

// File: rtl/hazard_unit_param_src_decode.sv
// rtl/hazard_unit_param_src_decode.sv - source register selection and per-source valid decode
module hazard_src_decode
    import hazard_unit_param_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               valid_i,
    output logic [REG_W-1:0]   src1_o,
    output logic [REG_W-1:0]   src2_o,
    output logic               src1_valid_o,
    output logic               src2_valid_o
);

    logic [63:0]      instr_ext;
    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] f_a;
    logic [REG_W-1:0] f_b;
    logic [REG_W-1:0] f_c;
    logic             is_lw;
    logic             is_sw;
    logic             is_lhb_llb;
    logic             no_src1;

    assign instr_ext = 64'(instr_i);
    assign opc       = OPC_W'(opc_field(instr_ext, INSTR_W, OPC_W));
    assign f_a       = REG_W'(fld_a(instr_ext, INSTR_W, OPC_W, REG_W));
    assign f_b       = REG_W'(fld_b(instr_ext, INSTR_W, OPC_W, REG_W));
    assign f_c       = REG_W'(fld_c(instr_ext, INSTR_W, OPC_W, REG_W));

    assign is_lw      = (opc == OPC_W'(OPC_LW));
    assign is_sw      = (opc == OPC_W'(OPC_SW));
    assign is_lhb_llb = (opc == OPC_W'(OPC_LHB)) || (opc == OPC_W'(OPC_LLB));
    assign no_src1    = (opc == OPC_W'(OPC_B)) || (opc == OPC_W'(OPC_JAL)) || (opc == OPC_W'(OPC_HLT));

    // SW and LHB/LLB read their field A as a source (store data / half being kept).
    assign src1_o       = (is_sw || is_lhb_llb) ? f_a : f_b;
    assign src2_o       = (is_sw || is_lw) ? f_b : f_c;
    assign src1_valid_o = valid_i && !no_src1;
    assign src2_valid_o = valid_i && (!opc[OPC_W-1] || is_sw);

endmodule

// File: rtl/hazard_unit_param.sv
// rtl/hazard_unit_param.sv - load-use stall and halt drain/latch control between IF/ID and ID/EX
module hazard_unit_param
    import hazard_unit_param_pkg::*;
#(
    parameter int INSTR_W       = 16,
    parameter int OPC_W         = 4,
    parameter int REG_W         = 4,
    parameter int LOAD_LAT      = 1,
    parameter int HLT_DRAIN     = 3,
    parameter int ZERO_REG_EXCL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INSTR_W-1:0] if_id_instr,
    input  logic               if_id_valid,
    input  logic [INSTR_W-1:0] id_ex_instr,
    input  logic               id_ex_valid,
    input  logic               id_ex_mem_to_reg,
    output logic               stall,
    output logic               bubble,
    output logic               hlt_out,
    output logic [1:0]         state_dbg
);

    localparam int CNT_MAX = (LOAD_LAT > HLT_DRAIN) ? LOAD_LAT : HLT_DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             src1_valid;
    logic             src2_valid;
    logic [REG_W-1:0] ex_dst;
    logic [OPC_W-1:0] id_opc;
    logic             match1;
    logic             match2;
    logic             load_use;
    logic             hlt_in_id;

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;

    hazard_src_decode #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .REG_W   (REG_W)
    ) u_src_decode (
        .instr_i      (if_id_instr),
        .valid_i      (if_id_valid),
        .src1_o       (src1),
        .src2_o       (src2),
        .src1_valid_o (src1_valid),
        .src2_valid_o (src2_valid)
    );

    assign ex_dst    = REG_W'(fld_a(64'(id_ex_instr), INSTR_W, OPC_W, REG_W));
    assign id_opc    = OPC_W'(opc_field(64'(if_id_instr), INSTR_W, OPC_W));
    assign hlt_in_id = if_id_valid && (id_opc == OPC_W'(OPC_HLT));

    assign match1   = src1_valid && (src1 == ex_dst) && ((ZERO_REG_EXCL == 0) || (src1 != '0));
    assign match2   = src2_valid && (src2 == ex_dst) && ((ZERO_REG_EXCL == 0) || (src2 != '0));
    assign load_use = id_ex_valid && id_ex_mem_to_reg && (match1 || match2);

    // ready_q keeps the unit quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && !flush) begin
                    if (load_use) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LOAD_STALL;
                            cnt_d   = CNT_W'(LOAD_LAT - 1);
                        end
                    end else if (hlt_in_id) begin
                        state_d = ST_HALT_DRAIN;
                        cnt_d   = CNT_W'(HLT_DRAIN);
                    end
                end
            end
            ST_LOAD_STALL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                end
            end
            ST_HALT_DRAIN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign hlt_out   = (state_q == ST_HALTED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// tb/tb_hazard_unit_param.sv - table, directed and randomized checks of hazard_unit_param against a reference model
module tb_hazard_unit_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] if_i;
    logic        if_v;
    logic [15:0] ex_i;
    logic        ex_v;
    logic        mtr;
    logic [1:0]  st_v;
    logic [1:0]  bb_v;
    logic [1:0]  hl_v;
    logic [1:0]  sd_a;
    logic [1:0]  sd_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_unit_param #(.LOAD_LAT(1), .HLT_DRAIN(3), .ZERO_REG_EXCL(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .if_id_instr(if_i), .if_id_valid(if_v),
        .id_ex_instr(ex_i), .id_ex_valid(ex_v), .id_ex_mem_to_reg(mtr),
        .stall(st_v[0]), .bubble(bb_v[0]), .hlt_out(hl_v[0]), .state_dbg(sd_a)
    );

    hazard_unit_param #(.LOAD_LAT(4), .HLT_DRAIN(2), .ZERO_REG_EXCL(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .if_id_instr(if_i), .if_id_valid(if_v),
        .id_ex_instr(ex_i), .id_ex_valid(ex_v), .id_ex_mem_to_reg(mtr),
        .stall(st_v[1]), .bubble(bb_v[1]), .hlt_out(hl_v[1]), .state_dbg(sd_b)
    );

    // Reference model: remaining stall cycles, remaining drain cycles, halted flag.
    int lat[2] = '{1, 4};
    int drn[2] = '{3, 2};
    int zx[2]  = '{1, 0};
    int m_rem[2];
    int m_drain[2];
    bit m_halt[2];
    bit m_ready[2];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic bit m_load_use(int k);
        int opc, fa, fb, fc, exa, s1, s2;
        bit u1, u2, h;
        opc = int'(if_i >> 12);
        fa  = int'((if_i >> 8) & 16'hF);
        fb  = int'((if_i >> 4) & 16'hF);
        fc  = int'(if_i & 16'hF);
        exa = int'((ex_i >> 8) & 16'hF);
        u1  = if_v && !(opc == 12 || opc == 13 || opc == 15);
        u2  = if_v && (opc < 8 || opc == 9);
        s1  = (opc == 9 || opc == 10 || opc == 11) ? fa : fb;
        s2  = (opc == 8 || opc == 9) ? fb : fc;
        h   = (u1 && s1 == exa && !(zx[k] != 0 && s1 == 0)) ||
              (u2 && s2 == exa && !(zx[k] != 0 && s2 == 0));
        return ex_v && mtr && h;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_ready[k] = 0;
        end
    endtask

    task automatic m_expect(input int k, output logic e_st, output logic e_bb, output logic e_h,
                            output logic [1:0] e_sd);
        e_st = 0; e_bb = 0; e_h = 0; e_sd = 2'd0;
        if (!m_ready[k] || !rst) begin
        end else if (m_halt[k]) begin
            e_st = 1; e_h = 1; e_sd = 2'd3;
        end else if (m_drain[k] > 0) begin
            e_sd = 2'd2;
        end else if (m_rem[k] > 0) begin
            e_sd = 2'd1; e_st = !flush; e_bb = !flush;
        end else begin
            e_st = !flush && m_load_use(k); e_bb = e_st;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_rem[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_ready[k] = 0;
            end else if (!m_ready[k]) begin
                m_ready[k] = 1;
            end else if (m_halt[k]) begin
            end else if (m_drain[k] > 0) begin
                if (flush) m_drain[k] = 0;
                else if (m_drain[k] == 1) begin m_drain[k] = 0; m_halt[k] = 1; end
                else m_drain[k]--;
            end else if (m_rem[k] > 0) begin
                m_rem[k] = flush ? 0 : m_rem[k] - 1;
            end else if (!flush) begin
                if (m_load_use(k)) m_rem[k] = lat[k] - 1;
                else if (if_v && if_i[15:12] == 4'hF) m_drain[k] = drn[k];
            end
        end
    endtask

    task automatic check_cycle(input string tag);
        logic e_st, e_bb, e_h;
        logic [1:0] e_sd;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            string u;
            u = (k == 0) ? "a" : "b";
            m_expect(k, e_st, e_bb, e_h, e_sd);
            chk($sformatf("%s.%s.stall", tag, u), 8'(st_v[k]), 8'(e_st));
            chk($sformatf("%s.%s.bubble", tag, u), 8'(bb_v[k]), 8'(e_bb));
            chk($sformatf("%s.%s.hlt", tag, u), 8'(hl_v[k]), 8'(e_h));
            chk($sformatf("%s.%s.state", tag, u), 8'((k == 0) ? sd_a : sd_b), 8'(e_sd));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic [15:0] ii, input logic iv, input logic [15:0] ei, input logic ev,
                          input logic m, input logic f);
        if_i = ii; if_v = iv; ex_i = ei; ex_v = ev; mtr = m; flush = f;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        set_in(16'h0, 0, 16'h0, 0, 0, 0);
        check_cycle("rst0");
        advance();
        check_cycle("rst1");
        advance();
        rst = 1'b1;
        check_cycle("rst_rel");
        advance();
    endtask

    typedef struct {
        logic [15:0] ifi;
        logic        ifv;
        logic [15:0] exi;
        logic        exv;
        logic        m;
        logic        fl;
        logic        ea;
        logic        eb;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{16'h0532, 1, 16'h8304, 1, 1, 0, 1, 1};  // ADD R5,R3,R2 after LW R3
        tbl[1]  = '{16'h0532, 1, 16'h8304, 1, 0, 0, 0, 0};  // producer not a load
        tbl[2]  = '{16'h0532, 1, 16'h8304, 0, 1, 0, 0, 0};  // EX slot empty
        tbl[3]  = '{16'h0532, 0, 16'h8304, 1, 1, 0, 0, 0};  // ID slot empty
        tbl[4]  = '{16'h0502, 1, 16'h8004, 1, 1, 0, 0, 1};  // R0 dependence
        tbl[5]  = '{16'hC030, 1, 16'h8304, 1, 1, 0, 0, 0};  // branch field B=3
        tbl[6]  = '{16'h9310, 1, 16'h8304, 1, 1, 0, 1, 1};  // SW data reg A=3
        tbl[7]  = '{16'h9130, 1, 16'h8304, 1, 1, 0, 1, 1};  // SW base B=3
        tbl[8]  = '{16'h8130, 1, 16'h8304, 1, 1, 0, 1, 1};  // LW base B=3
        tbl[9]  = '{16'h8103, 1, 16'h8304, 1, 1, 0, 0, 0};  // LW field C ignored
        tbl[10] = '{16'hA300, 1, 16'h8304, 1, 1, 0, 1, 1};  // LHB reads A
        tbl[11] = '{16'h0123, 1, 16'h8304, 1, 1, 0, 1, 1};  // ALU src2=C
        tbl[12] = '{16'hD333, 1, 16'h8304, 1, 1, 0, 0, 0};  // JAL no sources
        tbl[13] = '{16'hE030, 1, 16'h8304, 1, 1, 0, 1, 1};  // JR reads B
        tbl[14] = '{16'hF333, 1, 16'h8304, 1, 1, 0, 0, 0};  // HLT no sources
        tbl[15] = '{16'h0532, 1, 16'h8304, 1, 1, 1, 0, 0};  // flush beats hazard
        tbl[16] = '{16'h0300, 1, 16'h8304, 1, 1, 0, 0, 0};  // dst match only

        rst = 1'b0;
        model_clear();
        set_in(16'h0, 0, 16'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].ifi, tbl[i].ifv, tbl[i].exi, tbl[i].exv, tbl[i].m, tbl[i].fl);
            check_cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.a.tbl", i), 8'(st_v[0]), 8'(tbl[i].ea));
            chk($sformatf("vec%0d.b.tbl", i), 8'(st_v[1]), 8'(tbl[i].eb));
            advance();
            set_in(16'h0, 0, 16'h0, 0, 0, 1);
            check_cycle($sformatf("vec%0d_fl", i));
            advance();
        end
        set_in(16'h0, 0, 16'h0, 0, 0, 0);
        check_cycle("idle");
        chk("idle.b.state", 8'(sd_b), 8'd0);
        advance();

        // Load-use stall length: 1 cycle on a, 4 cycles on b.
        set_in(16'h0532, 1, 16'h8304, 1, 1, 0);
        check_cycle("lu0");
        chk("lu0.a", 8'(st_v[0]), 8'd1);
        chk("lu0.b", 8'(st_v[1]), 8'd1);
        chk("lu0.b.state", 8'(sd_b), 8'd0);
        advance();
        for (int c = 1; c <= 4; c++) begin
            set_in(16'h0532, 1, 16'h8304, 0, 1, 0);
            check_cycle($sformatf("lu%0d", c));
            chk($sformatf("lu%0d.a", c), 8'(st_v[0]), 8'd0);
            chk($sformatf("lu%0d.b", c), 8'(st_v[1]), (c < 4) ? 8'd1 : 8'd0);
            chk($sformatf("lu%0d.b.state", c), 8'(sd_b), (c < 4) ? 8'd1 : 8'd0);
            advance();
        end

        // Flush in the second stall cycle of b.
        set_in(16'h0532, 1, 16'h8304, 1, 1, 0);
        check_cycle("lufl0");
        advance();
        set_in(16'h0532, 1, 16'h8304, 0, 1, 1);
        check_cycle("lufl1");
        chk("lufl1.b.stall", 8'(st_v[1]), 8'd0);
        chk("lufl1.b.bubble", 8'(bb_v[1]), 8'd0);
        advance();
        set_in(16'h0, 0, 16'h0, 0, 0, 0);
        check_cycle("lufl2");
        chk("lufl2.b.state", 8'(sd_b), 8'd0);
        advance();

        // Halt: a latches 4 cycles after HLT in decode, b after 3; flush ignored once halted.
        for (int c = 0; c < 8; c++) begin
            if (c == 0) set_in(16'hF000, 1, 16'h0, 0, 0, 0);
            else set_in(16'h0, 0, 16'h0, 0, 0, (c == 6));
            check_cycle($sformatf("hlt%0d", c));
            chk($sformatf("hlt%0d.a.hlt", c), 8'(hl_v[0]), (c >= 4) ? 8'd1 : 8'd0);
            chk($sformatf("hlt%0d.a.stall", c), 8'(st_v[0]), (c >= 4) ? 8'd1 : 8'd0);
            chk($sformatf("hlt%0d.b.hlt", c), 8'(hl_v[1]), (c >= 3) ? 8'd1 : 8'd0);
            advance();
        end
        do_reset();

        // Flush two cycles after HLT aborts the drain on both units.
        for (int c = 0; c < 9; c++) begin
            if (c == 0) set_in(16'hF000, 1, 16'h0, 0, 0, 0);
            else set_in(16'h0, 0, 16'h0, 0, 0, (c == 2));
            check_cycle($sformatf("hfl%0d", c));
            chk($sformatf("hfl%0d.a.hlt", c), 8'(hl_v[0]), 8'd0);
            chk($sformatf("hfl%0d.b.hlt", c), 8'(hl_v[1]), 8'd0);
            advance();
        end

        // Asynchronous reset in the middle of a drain.
        set_in(16'hF000, 1, 16'h0, 0, 0, 0);
        check_cycle("hrst0");
        advance();
        set_in(16'h0, 0, 16'h0, 0, 0, 0);
        check_cycle("hrst1");
        chk("hrst1.a.state", 8'(sd_a), 8'd2);
        advance();
        rst = 1'b0;
        model_clear();
        check_cycle("hrst2");
        chk("hrst2.a.state", 8'(sd_a), 8'd0);
        chk("hrst2.a.stall", 8'(st_v[0]), 8'd0);
        chk("hrst2.b.state", 8'(sd_b), 8'd0);
        advance();
        rst = 1'b1;
        check_cycle("hrst3");
        advance();

        for (int it = 0; it < 400; it++) begin
            logic [3:0] op;
            if (it % 30 == 0) do_reset();
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            if_i  = {op, 2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
                     2'b00, 2'($urandom_range(0, 3))};
            ex_i  = {4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3)), 8'($urandom)};
            if_v  = ($urandom_range(0, 4) != 0);
            ex_v  = ($urandom_range(0, 4) != 0);
            mtr   = ($urandom_range(0, 1) != 0);
            flush = ($urandom_range(0, 9) == 0);
            check_cycle("rnd");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
